// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection, bubble insertion
// on stall or flush, and a saturating count of stall cycles.
module id_ex_stage #(
  parameter int XLEN   = 64,
  parameter int REGW   = 5,
  parameter int ALUOPW = 2,
  parameter int CNTW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REGW-1:0]   id_rs1,
  input  logic [REGW-1:0]   id_rs2,
  input  logic [REGW-1:0]   id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [5:0]        id_ctrl,
  input  logic [ALUOPW-1:0] id_alu_op,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REGW-1:0]   ex_rs1,
  output logic [REGW-1:0]   ex_rs2,
  output logic [REGW-1:0]   ex_rd,
  output logic [5:0]        ex_ctrl,
  output logic              ex_alu_src,
  output logic [ALUOPW-1:0] ex_alu_op,
  output logic              stall,
  output logic [CNTW-1:0]   stall_cnt
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [REGW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [5:0]        ctrl_q, ctrl_d;
  logic [ALUOPW-1:0] alu_op_q, alu_op_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              stall_w;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == '1) ? v : v + CNTW'(1);
  endfunction

  // Load in EX (mem_read = ctrl[1]) whose destination feeds a source read in ID.
  assign stall_w = id_valid & valid_q & ctrl_q[1] & (rd_q != '0) &
                   ((id_uses_rs1 & (id_rs1 == rd_q)) |
                    (id_uses_rs2 & (id_rs2 == rd_q)));

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    alu_op_d   = alu_op_q;
    cnt_d      = stall_w ? sat_inc(cnt_q) : cnt_q;
    if (flush || stall_w) begin
      // Bubble: kill control only; operand registers keep their old contents.
      valid_d  = 1'b0;
      ctrl_d   = '0;
      alu_op_d = '0;
      rd_d     = '0;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      alu_op_d   = id_alu_op;
      ctrl_d     = id_valid ? id_ctrl : 6'b0;
      rd_d       = id_valid ? id_rd : '0;
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      alu_op_q   <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      alu_op_q   <= alu_op_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_alu_src  = ctrl_q[0];
  assign ex_alu_op   = alu_op_q;
  assign stall       = stall_w;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues hand-computed expected
// EX state and stall per cycle; a monitor pops and compares against the DUT.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [63:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic [5:0]  id_ctrl = '0;
  logic [1:0]  id_alu_op = '0;
  logic        flush = 1'b0;

  logic        ex_valid, ex_alu_src, stall;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [5:0]  ex_ctrl;
  logic [1:0]  ex_alu_op;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        v;
    logic [63:0] pc, imm, r1d, r2d;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  ctrl;
    logic [1:0]  op;
    logic        st;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  id_ex_stage #(.XLEN(64), .REGW(5), .ALUOPW(2), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ctrl(id_ctrl), .id_alu_op(id_alu_op), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, req);
    end
  endtask

  // Drive one cycle of ID inputs and queue the EX state/stall expected in that cycle.
  // Operand data convention: rs1_data = pc+1, rs2_data = pc+2 (zero while EX is in reset).
  task automatic drv(input string nm, input logic rst, input logic fl,
                     input logic v, input logic [63:0] pc, input logic [63:0] imm,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic u1, input logic u2, input logic [5:0] ctrl,
                     input logic [1:0] op,
                     input logic ev, input logic [63:0] epc, input logic [63:0] eimm,
                     input logic [4:0] ers1, input logic [4:0] ers2, input logic [4:0] erd,
                     input logic [5:0] ectrl, input logic [1:0] eop,
                     input logic est, input logic [3:0] ecnt);
    exp_t e;
    @(negedge clk);
    #1;
    reset = rst; flush = fl; id_valid = v; id_pc = pc; id_imm = imm;
    id_rs1_data = pc + 64'd1; id_rs2_data = pc + 64'd2;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_ctrl = ctrl; id_alu_op = op;
    e.nm = nm; e.v = ev; e.pc = epc; e.imm = eimm;
    e.r1d = (epc == 64'd0) ? 64'd0 : epc + 64'd1;
    e.r2d = (epc == 64'd0) ? 64'd0 : epc + 64'd2;
    e.rs1 = ers1; e.rs2 = ers2; e.rd = erd; e.ctrl = ectrl; e.op = eop;
    e.st = est; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  // Monitor: samples after the driver has settled the ID inputs for the cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "ex_valid",    64'(ex_valid),    64'(e.v));
        chk(e.nm, "ex_pc",       ex_pc,            e.pc);
        chk(e.nm, "ex_imm",      ex_imm,           e.imm);
        chk(e.nm, "ex_rs1_data", ex_rs1_data,      e.r1d);
        chk(e.nm, "ex_rs2_data", ex_rs2_data,      e.r2d);
        chk(e.nm, "ex_rs1",      64'(ex_rs1),      64'(e.rs1));
        chk(e.nm, "ex_rs2",      64'(ex_rs2),      64'(e.rs2));
        chk(e.nm, "ex_rd",       64'(ex_rd),       64'(e.rd));
        chk(e.nm, "ex_ctrl",     64'(ex_ctrl),     64'(e.ctrl));
        chk(e.nm, "ex_alu_src",  64'(ex_alu_src),  64'(e.ctrl[0]));
        chk(e.nm, "ex_alu_op",   64'(ex_alu_op),   64'(e.op));
        chk(e.nm, "stall",       64'(stall),       64'(e.st));
        chk(e.nm, "stall_cnt",   64'(stall_cnt),   64'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    //        name       rst fl v  pc     imm   rs1 rs2 rd u1 u2 ctrl       op   ev epc    eimm  ers1 ers2 erd ectrl      eop st cnt
    drv("reset",   0, 0, 1, 'h100, 'h10, 1, 2, 3, 1, 1, 6'b000101, 2,  0, 0,     0,    0, 0, 0, 6'b000000, 0, 0, 0);
    drv("load",    0, 0, 1, 'h104, 'h8,  3, 0, 5, 1, 0, 6'b011011, 0,  1, 'h100, 'h10, 1, 2, 3, 6'b000101, 2, 0, 0);
    drv("ldx5",    0, 0, 1, 'h108, 0,    5, 6, 7, 1, 1, 6'b001000, 2,  1, 'h104, 'h8,  3, 0, 5, 6'b011011, 0, 1, 0);
    drv("bubble",  0, 0, 1, 'h108, 0,    5, 6, 7, 1, 1, 6'b001000, 2,  0, 'h104, 'h8,  3, 0, 0, 6'b000000, 0, 0, 1);
    drv("addex",   0, 0, 1, 'h10c, 0,    1, 0, 0, 1, 0, 6'b011011, 0,  1, 'h108, 0,    5, 6, 7, 6'b001000, 2, 0, 1);
    drv("x0",      0, 0, 1, 'h110, 0,    0, 3, 8, 1, 1, 6'b001000, 2,  1, 'h10c, 0,    1, 0, 0, 6'b011011, 0, 0, 1);
    drv("addx0",   0, 0, 1, 'h114, 'h4,  2, 0, 5, 1, 0, 6'b011011, 0,  1, 'h110, 0,    0, 3, 8, 6'b001000, 2, 0, 1);
    drv("mask",    0, 0, 1, 'h118, 0,    1, 5, 9, 1, 0, 6'b001000, 2,  1, 'h114, 'h4,  2, 0, 5, 6'b011011, 0, 0, 1);
    drv("mask_ex", 0, 0, 1, 'h11c, 'h8,  1, 0, 6, 1, 0, 6'b011011, 0,  1, 'h118, 0,    1, 5, 9, 6'b001000, 2, 0, 1);
    drv("rs2st",   0, 0, 1, 'h120, 0,    1, 6, 0, 1, 1, 6'b000101, 0,  1, 'h11c, 'h8,  1, 0, 6, 6'b011011, 0, 1, 1);
    drv("bubble2", 0, 0, 1, 'h120, 0,    1, 6, 0, 1, 1, 6'b000101, 0,  0, 'h11c, 'h8,  1, 0, 0, 6'b000000, 0, 0, 2);
    drv("sdex",    0, 1, 1, 'h124, 'h20, 7, 8, 9, 1, 1, 6'b111111, 3,  1, 'h120, 0,    1, 6, 0, 6'b000101, 0, 0, 2);
    drv("flush",   0, 0, 0, 'h128, 'h30, 0, 0, 4, 0, 0, 6'b111111, 0,  0, 'h120, 0,    1, 6, 0, 6'b000000, 0, 0, 2);
    drv("idinv",   0, 0, 1, 'h12c, 0,    1, 0, 5, 1, 0, 6'b011011, 0,  0, 'h128, 'h30, 0, 0, 0, 6'b000000, 0, 0, 2);
    drv("flshst",  0, 1, 1, 'h130, 0,    5, 0, 7, 1, 0, 6'b001000, 2,  1, 'h12c, 0,    1, 0, 5, 6'b011011, 0, 1, 2);
    drv("flshbub", 0, 0, 0, 'h140, 0,    0, 0, 0, 0, 0, 6'b000000, 0,  0, 'h12c, 0,    1, 0, 0, 6'b000000, 0, 0, 3);
    // Self-dependent load in ID: stalls every other cycle; 20 stalls saturate the 4-bit count.
    for (int k = 0; k < 42; k++) begin
      if (k == 0)
        drv("sat", 0, 0, 1, 'h200, 0, 5, 0, 5, 1, 0, 6'b011011, 0,
            0, 'h140, 0, 0, 0, 0, 6'b000000, 0, 0, 3);
      else if (k % 2 == 1) begin
        c = 3 + (k - 1) / 2;
        if (c > 15) c = 15;
        drv("sat", (k == 41), 0, 1, 'h200, 0, 5, 0, 5, 1, 0, 6'b011011, 0,
            1, 'h200, 0, 5, 0, 5, 6'b011011, 0, 1, 4'(c));
      end else begin
        c = 3 + k / 2;
        if (c > 15) c = 15;
        drv("sat", 0, 0, 1, 'h200, 0, 5, 0, 5, 1, 0, 6'b011011, 0,
            0, 'h200, 0, 5, 0, 0, 6'b000000, 0, 0, 4'(c));
      end
    end
    drv("rstmid",  0, 0, 1, 'h200, 0,    5, 0, 5, 1, 0, 6'b011011, 0,  0, 0,     0,    0, 0, 0, 6'b000000, 0, 0, 0);
    drv("reload",  0, 0, 1, 'h200, 0,    5, 0, 5, 1, 0, 6'b011011, 0,  1, 'h200, 0,    5, 0, 5, 6'b011011, 0, 1, 0);
    drv("final",   0, 0, 0, 0,     0,    0, 0, 0, 0, 0, 6'b000000, 0,  0, 'h200, 0,    5, 0, 0, 6'b000000, 0, 0, 1);
    repeat (3) @(negedge clk);
    #3;
    chk("drain", "queue_left", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
